// File: rtl/alu_pkg.sv
// alu_pkg: opcode and multiplier-state encodings shared by alu_seq and alu_mul_seq.
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_XOR   = 3'b010,
        ALU_SHIFT = 3'b011,
        ALU_MUL   = 3'b100
    } alu_op_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH cycles.
`default_nettype none

module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    mul_state_e           state;
    mul_state_e           state_nx;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   addend;

    // The final partial product is folded in combinationally so the result
    // is available on the same edge as the last iteration.
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start) begin
                    state_nx = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    done     = 1'b1;
                    state_nx = MUL_IDLE;
                end
            end
            default: state_nx = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == MUL_IDLE) begin
            if (start) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= '0;
            end
        end else begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: registered ALU (add/sub, and, xor, shift) with flags and tristate result bus.
// Optional iterative multiply is built only when ALU_MUL_EN is defined.
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_nReset,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [2:0]         i_aluOp,
    input  logic               i_subShiftDir,
    input  logic               i_aluWr,
    input  logic               i_noe,
    output wire  [WIDTH-1:0]   o_y,
    output logic               o_negative,
    output logic               o_nZero,
    output logic               o_carry,
    output logic               o_busy,
    output logic               o_done
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_e            op;
    logic [WIDTH-1:0]   y_reg;
    logic               carry_reg;
    logic               done_reg;
    logic               busy;
    logic               start;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   single_y;
    logic               single_op;
    logic               wr_carry;

    assign op    = alu_op_e'(i_aluOp);
    assign start = i_aluWr && !busy;

    always_comb begin
        sum = {1'b0, i_a}
            + {1'b0, i_b ^ {WIDTH{i_subShiftDir}}}
            + {{WIDTH{1'b0}}, i_subShiftDir};
        single_y  = y_reg;
        single_op = 1'b1;
        wr_carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                single_y = sum[WIDTH-1:0];
                wr_carry = 1'b1;
            end
            ALU_AND:   single_y = i_a & i_b;
            ALU_XOR:   single_y = i_a ^ i_b;
            ALU_SHIFT: single_y = i_subShiftDir ? (i_a << i_b[SHW-1:0])
                                                : (i_a >> i_b[SHW-1:0]);
`ifdef ALU_MUL_EN
            ALU_MUL:   single_op = 1'b0;
`endif
            // Unsupported opcodes keep y_reg as-is but still pulse done.
            default:   single_y = y_reg;
        endcase
    end

`ifdef ALU_MUL_EN
    logic                 mul_done;
    logic                 mul_hi;
    logic [2*WIDTH-1:0]   mul_product;

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (i_clk),
        .rst_n   (i_nReset),
        .start   (start && !single_op),
        .a       (i_a),
        .b       (i_b),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            y_reg     <= '0;
            carry_reg <= 1'b0;
            done_reg  <= 1'b0;
`ifdef ALU_MUL_EN
            mul_hi    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (start && single_op) begin
                y_reg    <= single_y;
                done_reg <= 1'b1;
                if (wr_carry) begin
                    carry_reg <= sum[WIDTH];
                end
            end
`ifdef ALU_MUL_EN
            if (start && !single_op) begin
                mul_hi <= i_subShiftDir;
            end
            if (mul_done) begin
                y_reg    <= mul_hi ? mul_product[2*WIDTH-1:WIDTH]
                                   : mul_product[WIDTH-1:0];
                done_reg <= 1'b1;
            end
`endif
        end
    end

    assign o_y        = i_noe ? {WIDTH{1'bz}} : y_reg;
    assign o_negative = y_reg[WIDTH-1];
    assign o_nZero    = |y_reg;
    assign o_carry    = carry_reg;
    assign o_busy     = busy;
    assign o_done     = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8 and WIDTH=16.
`default_nettype none

module tb_alu_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  op8 = '0;
    logic        sub8 = 1'b0, wr8 = 1'b0, noe8 = 1'b0;
    wire  [7:0]  y8;
    wire         neg8, nz8, c8, busy8, done8;

    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  op16 = '0;
    logic        sub16 = 1'b0, wr16 = 1'b0;
    wire  [15:0] y16;
    wire         neg16, nz16, c16, busy16, done16;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .i_clk         (clk),
        .i_nReset      (rst_n),
        .i_a           (a8),
        .i_b           (b8),
        .i_aluOp       (op8),
        .i_subShiftDir (sub8),
        .i_aluWr       (wr8),
        .i_noe         (noe8),
        .o_y           (y8),
        .o_negative    (neg8),
        .o_nZero       (nz8),
        .o_carry       (c8),
        .o_busy        (busy8),
        .o_done        (done8)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .i_clk         (clk),
        .i_nReset      (rst_n),
        .i_a           (a16),
        .i_b           (b16),
        .i_aluOp       (op16),
        .i_subShiftDir (sub16),
        .i_aluWr       (wr16),
        .i_noe         (1'b0),
        .o_y           (y16),
        .o_negative    (neg16),
        .o_nZero       (nz16),
        .o_carry       (c16),
        .o_busy        (busy16),
        .o_done        (done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sub);
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; sub8 = sub; wr8 = 1'b1;
        @(posedge clk);
        #1;
        wr8 = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic sub);
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; sub16 = sub; wr16 = 1'b1;
        @(posedge clk);
        #1;
        wr16 = 1'b0;
    endtask

    task automatic expect8(input string tag, input logic [7:0] y, input logic c);
        check({tag, "_y"},    32'(y8),    32'(y));
        check({tag, "_c"},    32'(c8),    32'(c));
        check({tag, "_done"}, 32'(done8), 'h1);
        check({tag, "_busy"}, 32'(busy8), 'h0);
    endtask

`ifdef ALU_MUL_EN
    task automatic mul8(input string tag, input logic sub, input logic [7:0] y_prev,
                        input logic [7:0] y_exp);
        int busy_cycles;
        int unstable;
        busy_cycles = 0;
        unstable    = 0;
        issue8(3'b100, 8'hFF, 8'hFF, sub);
        check({tag, "_start_done"}, 32'(done8), 'h0);
        for (int k = 0; k < 20 && busy8; k++) begin
            busy_cycles++;
            if (y8 !== y_prev || done8 !== 1'b0) unstable++;
            if (k == 3) begin
                op8 = 3'b000; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; wr8 = 1'b1;
            end else begin
                wr8 = 1'b0;
                a8  = 8'h3C;
            end
            @(posedge clk);
            #1;
        end
        wr8 = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 'd8);
        check({tag, "_stable"},      32'(unstable),    'd0);
        expect8(tag, y_exp, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_noqueue_done"}, 32'(done8), 'h0);
        check({tag, "_noqueue_busy"}, 32'(busy8), 'h0);
    endtask
`endif

    initial begin
        #2;
        check("rst_y",    32'(y8),    'h00);
        check("rst_c",    32'(c8),    'h0);
        check("rst_nz",   32'(nz8),   'h0);
        check("rst_neg",  32'(neg8),  'h0);
        check("rst_busy", 32'(busy8), 'h0);
        check("rst_done", 32'(done8), 'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue8(3'b000, 8'hFF, 8'h01, 1'b0);
        expect8("add_ff_01", 8'h00, 1'b1);
        check("add_ff_01_nz", 32'(nz8), 'h0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done8), 'h0);

        issue8(3'b001, 8'hF0, 8'h3C, 1'b0);
        expect8("and", 8'h30, 1'b1);
        issue8(3'b010, 8'hA5, 8'h0F, 1'b0);
        expect8("xor", 8'hAA, 1'b1);
        check("xor_neg", 32'(neg8), 'h1);

        issue8(3'b000, 8'h05, 8'h07, 1'b1);
        expect8("sub_05_07", 8'hFE, 1'b0);
        check("sub_05_07_neg", 32'(neg8), 'h1);
        check("sub_05_07_nz",  32'(nz8),  'h1);
        issue8(3'b000, 8'h07, 8'h05, 1'b1);
        expect8("sub_07_05", 8'h02, 1'b1);

        issue8(3'b011, 8'h81, 8'h03, 1'b0);
        expect8("shr3", 8'h10, 1'b1);
        issue8(3'b011, 8'h81, 8'h03, 1'b1);
        expect8("shl3", 8'h08, 1'b1);
        issue8(3'b011, 8'h81, 8'h0B, 1'b0);
        expect8("shr_amt_masked", 8'h10, 1'b1);
        issue8(3'b011, 8'h81, 8'h00, 1'b0);
        expect8("sh0", 8'h81, 1'b1);

        issue8(3'b111, 8'h00, 8'h00, 1'b1);
        expect8("illegal", 8'h81, 1'b1);

        noe8 = 1'b1;
        #1;
        check("noe_hiz",     32'(y8 !== 8'h81), 'h1);
        check("noe_neg_kept", 32'(neg8), 'h1);
        noe8 = 1'b0;
        #1;
        check("noe_drive", 32'(y8), 'h81);

`ifdef ALU_MUL_EN
        mul8("mul_hi", 1'b1, 8'h81, 8'hFE);
        mul8("mul_lo", 1'b0, 8'hFE, 8'h01);
        issue8(3'b100, 8'hFF, 8'hFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_run_busy", 32'(busy8), 'h1);
`else
        issue8(3'b100, 8'h03, 8'h05, 1'b1);
        expect8("mul_disabled", 8'h81, 1'b1);
`endif

        rst_n = 1'b0;
        #1;
        check("async_rst_y",    32'(y8),    'h00);
        check("async_rst_c",    32'(c8),    'h0);
        check("async_rst_busy", 32'(busy8), 'h0);
        check("async_rst_done", 32'(done8), 'h0);
        check("async_rst_nz",   32'(nz8),   'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue8(3'b000, 8'h12, 8'h34, 1'b0);
        expect8("add_after_rst", 8'h46, 1'b0);

        issue16(3'b000, 16'hFFFF, 16'h0001, 1'b0);
        check("w16_add_y",    32'(y16),    'h0000);
        check("w16_add_c",    32'(c16),    'h1);
        check("w16_add_nz",   32'(nz16),   'h0);
        check("w16_add_done", 32'(done16), 'h1);
        issue16(3'b000, 16'h0005, 16'h0007, 1'b1);
        check("w16_sub_y",   32'(y16),   'hFFFE);
        check("w16_sub_c",   32'(c16),   'h0);
        check("w16_sub_neg", 32'(neg16), 'h1);
        issue16(3'b011, 16'h8001, 16'h0003, 1'b0);
        check("w16_shr3", 32'(y16), 'h1000);
        issue16(3'b011, 16'h8001, 16'h0003, 1'b1);
        check("w16_shl3", 32'(y16), 'h0008);
        issue16(3'b011, 16'h0001, 16'h000F, 1'b1);
        check("w16_shl15",   32'(y16),    'h8000);
        check("w16_busy",    32'(busy16), 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
